ifetch_buffer: RTL and testbench

IFETCH_BUFFER -- requirements
Module: ifetch_buffer

---
 rtl/ifetch_buffer.sv | 84 ++++++++
 tb/tb_ifetch_buffer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_buffer.sv
// Instruction prefetch queue: keeps one ROM read in flight and buffers returned
// words with their fetch address until the CPU consumes them; jumps flush and redirect.
module ifetch_buffer #(
  parameter logic [15:0] RESET_ADDR = 16'h0000,
  parameter int          DEPTH      = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clk_en,
  output logic [15:0] o_rom_addr,
  input  logic [23:0] i_rom_data,
  output logic        o_valid,
  output logic [23:0] o_instr,
  output logic [15:0] o_instr_addr,
  input  logic        i_cpu_ready,
  input  logic        i_jump,
  input  logic [15:0] i_jump_addr,
  output logic [4:0]  o_level
);
  localparam int PW = $clog2(DEPTH);

  logic [15:0]   pc;
  logic          inflight;
  logic [15:0]   inflight_addr;
  logic [23:0]   q_instr [DEPTH];
  logic [15:0]   q_addr  [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    level;
  logic [4:0]    occupancy;
  logic          jump_en, issue, ret, pop;

  assign jump_en    = i_clk_en & i_jump;
  assign occupancy  = level + {4'd0, inflight};
  // Counting the in-flight word reserves its slot, so a write never lands on a full queue.
  assign issue      = jump_en | (i_clk_en & (occupancy < 5'(DEPTH)));
  assign ret        = i_clk_en & inflight & ~i_jump;
  assign pop        = i_clk_en & o_valid & i_cpu_ready & ~i_jump;

  assign o_rom_addr   = i_jump ? i_jump_addr : pc;
  assign o_valid      = (level != 5'd0);
  assign o_level      = level;
  assign o_instr      = q_instr[rd_ptr];
  assign o_instr_addr = q_addr[rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc            <= RESET_ADDR;
      inflight      <= 1'b0;
      inflight_addr <= 16'h0000;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= 5'd0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= 24'h000000;
        q_addr[i]  <= 16'h0000;
      end
    end else if (i_clk_en) begin
      inflight <= issue;
      if (issue) begin
        inflight_addr <= o_rom_addr;
        pc            <= o_rom_addr + 16'd1;
      end
      if (i_jump) begin
        // Flush: whatever returns this cycle belongs to the old stream and is dropped.
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= 5'd0;
      end else begin
        if (ret) begin
          q_instr[wr_ptr] <= i_rom_data;
          q_addr[wr_ptr]  <= inflight_addr;
          wr_ptr          <= wr_ptr + PW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        case ({ret, pop})
          2'b10:   level <= level + 5'd1;
          2'b01:   level <= level - 5'd1;
          default: level <= level;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ifetch_buffer.sv
// Randomized bench: the expected instruction stream is a run of consecutive
// addresses starting at the reset or jump target; a monitor checks every pop.
module tb_ifetch_buffer;
  localparam logic [15:0] RESET_ADDR = 16'h0000;
  localparam int          DEPTH      = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [15:0] rom_addr;
  logic [23:0] rom_data;
  logic        valid;
  logic [23:0] instr;
  logic [15:0] instr_addr;
  logic        cpu_ready;
  logic        jump;
  logic [15:0] jump_addr;
  logic [4:0]  level;

  int tests = 0;
  int fails = 0;
  int pops  = 0;

  logic [39:0] exp_q [$];
  logic [15:0] stream_next;

  ifetch_buffer #(.RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .o_rom_addr(rom_addr),
    .i_rom_data(rom_data), .o_valid(valid), .o_instr(instr),
    .o_instr_addr(instr_addr), .i_cpu_ready(cpu_ready), .i_jump(jump),
    .i_jump_addr(jump_addr), .o_level(level)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] rom(input logic [15:0] a);
    return {8'h00, a} + 24'h000100;
  endfunction

  // Synchronous ROM: data for an address appears one enabled cycle later.
  always @(posedge clk) if (clk_en) rom_data <= rom(rom_addr);

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back({stream_next, rom(stream_next)});
      stream_next = stream_next + 16'd1;
    end
  endtask

  task automatic restart(input logic [15:0] a);
    exp_q.delete();
    stream_next = a;
    topup();
  endtask

  // Advance to just after the next rising edge; inputs change only here.
  task automatic cyc();
    @(posedge clk); #1;
    jump = 1'b0;
    topup();
  endtask

  task automatic do_jump(input logic [15:0] a);
    jump      = 1'b1;
    jump_addr = a;
    if (clk_en) restart(a);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    restart(RESET_ADDR);
    cyc();
    rst = 1'b0;
  endtask

  // Monitor: consume expected entries on each pop and check handshake invariants.
  logic        prev_valid, prev_pop, prev_jump;
  logic [39:0] prev_head;
  initial begin
    prev_valid = 1'b0; prev_pop = 1'b0; prev_jump = 1'b0; prev_head = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0; prev_pop = 1'b0; prev_jump = 1'b0;
      end else begin
        check("level_bound", 40'(level <= 5'(DEPTH)), 40'd1);
        check("valid_vs_level", 40'(valid), 40'(level != 5'd0));
        if (prev_jump)
          check("valid_after_jump", 40'(valid), 40'd0);
        if (prev_valid && !prev_pop && !prev_jump && valid)
          check("head_stable", {instr_addr, instr}, prev_head);
        prev_pop  = valid & cpu_ready & clk_en & ~jump;
        prev_jump = jump & clk_en;
        prev_valid = valid;
        prev_head  = {instr_addr, instr};
        if (prev_pop) begin
          pops++;
          if (exp_q.size() == 0) check("pop_unexpected", {instr_addr, instr}, 40'hx);
          else check("pop_entry", {instr_addr, instr}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; clk_en = 1'b1; cpu_ready = 1'b0; jump = 1'b0; jump_addr = 16'h0;
    restart(RESET_ADDR);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 40'(valid), 40'd0);
    check("rst_level", 40'(level), 40'd0);
    check("rst_instr", 40'(instr), 40'd0);
    check("rst_instr_addr", 40'(instr_addr), 40'd0);
    check("rst_rom_addr", 40'(rom_addr), 40'(RESET_ADDR));

    // Reset release latency and streaming at one entry per cycle.
    rst = 1'b0; cpu_ready = 1'b1;
    @(negedge clk);
    check("first_issue_addr", 40'(rom_addr), 40'(RESET_ADDR));
    check("lat_c0_valid", 40'(valid), 40'd0);
    cyc(); @(negedge clk);
    check("lat_c1_valid", 40'(valid), 40'd0);
    cyc(); @(negedge clk);
    check("lat_c2_valid", 40'(valid), 40'd1);
    repeat (10) cyc();

    // Stalled CPU: queue saturates and fetch address freezes.
    cpu_ready = 1'b0;
    do_reset();
    repeat (10) cyc();
    @(negedge clk);
    check("full_level", 40'(level), 40'(DEPTH));
    check("full_rom_addr", 40'(rom_addr), 40'(RESET_ADDR + 16'(DEPTH)));
    cyc(); @(negedge clk);
    check("full_rom_addr_hold", 40'(rom_addr), 40'(RESET_ADDR + 16'(DEPTH)));

    // Jump with pop requested on a full queue: no pop, flush, redirect.
    cpu_ready = 1'b1;
    do_jump(16'h0200);
    @(negedge clk);
    check("jump_rom_addr", 40'(rom_addr), 40'h0200);
    cyc(); @(negedge clk);
    check("jump_flush_level", 40'(level), 40'd0);
    repeat (8) cyc();

    // Jump near top of address space: stream wraps to 0x0000.
    do_jump(16'hFFFE);
    repeat (10) cyc();

    // Clock enable toggling; jumps while disabled must be ignored.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      clk_en = ~clk_en;
      if (!clk_en && (i % 6 == 1)) do_jump(16'(16'h4000 + i));
      cyc();
    end
    clk_en = 1'b1;

    // Reset while the queue fills with a read outstanding.
    cpu_ready = 1'b0;
    do_reset();
    repeat (3) cyc();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", 40'(valid), 40'd0);
    check("midrst_level", 40'(level), 40'd0);
    restart(RESET_ADDR);
    cyc();
    rst = 1'b0;
    cpu_ready = 1'b1;
    repeat (10) cyc();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      clk_en    = ($urandom_range(0, 3) != 0);
      cpu_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 24) == 0)
        do_jump(($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'(16'hFFFC + $urandom_range(0, 3)));
      cyc();
    end
    @(negedge clk);
    check("progress_pops", 40'(pops >= 300), 40'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
